// File: rtl/clock_core_if.sv
// rtl/clock_core_if.sv - time-load request/response bundle for clock_core
interface clock_core_if #(
    parameter int P_SEC_BIT  = 6,
    parameter int P_MIN_BIT  = 6,
    parameter int P_HOUR_BIT = 5
);
    logic                  load_valid;
    logic [P_SEC_BIT-1:0]  load_sec;
    logic [P_MIN_BIT-1:0]  load_min;
    logic [P_HOUR_BIT-1:0] load_hour;
    logic                  load_err;

    modport master (output load_valid, load_sec, load_min, load_hour, input load_err);
    modport slave  (input load_valid, load_sec, load_min, load_hour, output load_err);
endinterface

// File: rtl/clock_core.sv
// rtl/clock_core.sv - prescaled sec/min/hour time-of-day counter with 12/24h view and validated load
// Optional alarm comparator enabled by defining CLOCK_ALARM_EN.
module clock_core #(
    parameter int P_COUNT_BIT = 30,
    parameter int P_SEC_BIT   = 6,
    parameter int P_MIN_BIT   = 6,
    parameter int P_HOUR_BIT  = 5,
    parameter int P_HOURS     = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic [P_COUNT_BIT-1:0] i_freq,
    input  logic                   mode_12h,
    clock_core_if.slave            ld,
    output logic [P_SEC_BIT-1:0]   sec,
    output logic [P_MIN_BIT-1:0]   min,
    output logic [P_HOUR_BIT-1:0]  hour,
    output logic                   pm,
    output logic                   sec_tic,
    output logic                   min_tic,
    output logic                   hour_tic,
    output logic                   day_tic,
    input  logic [P_HOUR_BIT-1:0]  alarm_hour,
    input  logic [P_MIN_BIT-1:0]   alarm_min,
    input  logic                   alarm_arm,
    output logic                   alarm_hit
);
    localparam logic [P_COUNT_BIT-1:0] CNT_ONE  = P_COUNT_BIT'(1);
    localparam logic [P_SEC_BIT-1:0]   SEC_MAX  = P_SEC_BIT'(59);
    localparam logic [P_MIN_BIT-1:0]   MIN_MAX  = P_MIN_BIT'(59);
    localparam logic [P_HOUR_BIT-1:0]  HOUR_MAX = P_HOUR_BIT'(P_HOURS - 1);
    localparam logic [P_HOUR_BIT-1:0]  HOUR_12  = P_HOUR_BIT'(12);

    logic [P_COUNT_BIT-1:0] cnt_q, cnt_d;
    logic [P_SEC_BIT-1:0]   sec_q, sec_d;
    logic [P_MIN_BIT-1:0]   min_q, min_d;
    logic [P_HOUR_BIT-1:0]  hour_q, hour_d;
    logic sec_tic_q, sec_tic_d, min_tic_q, min_tic_d;
    logic hour_tic_q, hour_tic_d, day_tic_q, day_tic_d;
    logic load_err_q, load_err_d;
    logic load_ok, wrap;

    assign load_ok = (ld.load_sec <= SEC_MAX) && (ld.load_min <= MIN_MAX) &&
                     (ld.load_hour <= HOUR_MAX);
    // A count already past a freshly lowered i_freq-1 wraps on the next enabled cycle.
    assign wrap    = (i_freq <= CNT_ONE) || (cnt_q >= i_freq - CNT_ONE);

    always_comb begin
        cnt_d      = cnt_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        sec_tic_d  = 1'b0;
        min_tic_d  = 1'b0;
        hour_tic_d = 1'b0;
        day_tic_d  = 1'b0;
        load_err_d = 1'b0;
        if (ld.load_valid && load_ok) begin
            cnt_d  = '0;
            sec_d  = ld.load_sec;
            min_d  = ld.load_min;
            hour_d = ld.load_hour;
        end else begin
            load_err_d = ld.load_valid;
            if (en) begin
                if (wrap) begin
                    cnt_d     = '0;
                    sec_tic_d = 1'b1;
                    if (sec_q == SEC_MAX) begin
                        sec_d     = '0;
                        min_tic_d = 1'b1;
                        if (min_q == MIN_MAX) begin
                            min_d      = '0;
                            hour_tic_d = 1'b1;
                            if (hour_q == HOUR_MAX) begin
                                hour_d    = '0;
                                day_tic_d = 1'b1;
                            end else begin
                                hour_d = hour_q + P_HOUR_BIT'(1);
                            end
                        end else begin
                            min_d = min_q + P_MIN_BIT'(1);
                        end
                    end else begin
                        sec_d = sec_q + P_SEC_BIT'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            sec_tic_q  <= 1'b0;
            min_tic_q  <= 1'b0;
            hour_tic_q <= 1'b0;
            day_tic_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            sec_tic_q  <= sec_tic_d;
            min_tic_q  <= min_tic_d;
            hour_tic_q <= hour_tic_d;
            day_tic_q  <= day_tic_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef CLOCK_ALARM_EN
    logic alarm_hit_q, alarm_hit_d;

    // Only a counted minute rollover can fire; loads never raise min_tic_d.
    always_comb begin
        alarm_hit_d = min_tic_d && alarm_arm && (hour_d == alarm_hour) && (min_d == alarm_min);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) alarm_hit_q <= 1'b0;
        else          alarm_hit_q <= alarm_hit_d;
    end

    assign alarm_hit = alarm_hit_q;
`else
    logic alarm_unused;
    assign alarm_unused = &{1'b0, alarm_hour, alarm_min, alarm_arm};
    assign alarm_hit    = 1'b0;
`endif

    always_comb begin
        hour = hour_q;
        if (mode_12h) begin
            if (hour_q == '0)          hour = HOUR_12;
            else if (hour_q > HOUR_12) hour = hour_q - HOUR_12;
        end
    end

    assign pm          = (hour_q >= HOUR_12);
    assign sec         = sec_q;
    assign min         = min_q;
    assign sec_tic     = sec_tic_q;
    assign min_tic     = min_tic_q;
    assign hour_tic    = hour_tic_q;
    assign day_tic     = day_tic_q;
    assign ld.load_err = load_err_q;
endmodule

// File: tb/tb_clock_core.sv
// tb/tb_clock_core.sv - directed self-checking bench for clock_core
module tb_clock_core;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [29:0] i_freq;
    logic        mode_12h;
    logic [5:0]  sec, min;
    logic [4:0]  hour;
    logic        pm, sec_tic, min_tic, hour_tic, day_tic;
    logic [4:0]  alarm_hour;
    logic [5:0]  alarm_min;
    logic        alarm_arm, alarm_hit;
    int          checks = 0;
    int          failures = 0;
    int          tic_cnt;
    logic        exp_alarm;

    clock_core_if #(.P_SEC_BIT(6), .P_MIN_BIT(6), .P_HOUR_BIT(5)) ld ();

    clock_core dut (
        .clk(clk), .reset_n(reset_n), .en(en), .i_freq(i_freq), .mode_12h(mode_12h),
        .ld(ld.slave), .sec(sec), .min(min), .hour(hour), .pm(pm),
        .sec_tic(sec_tic), .min_tic(min_tic), .hour_tic(hour_tic), .day_tic(day_tic),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_arm(alarm_arm),
        .alarm_hit(alarm_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        ld.load_valid = 1'b1;
        ld.load_hour  = h;
        ld.load_min   = m;
        ld.load_sec   = s;
        step(1);
        ld.load_valid = 1'b0;
    endtask

    task automatic chk_time(input string tag, input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s);
        chk({tag, "_time"}, {8'd0, 3'd0, hour, 2'd0, min, 2'd0, sec},
            {8'd0, 3'd0, h, 2'd0, m, 2'd0, s});
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1; i_freq = 30'd4; mode_12h = 1'b0;
        ld.load_valid = 1'b0; ld.load_sec = '0; ld.load_min = '0; ld.load_hour = '0;
        alarm_hour = 5'd0; alarm_min = 6'd1; alarm_arm = 1'b1;
        exp_alarm = 1'b0;
`ifdef CLOCK_ALARM_EN
        exp_alarm = 1'b1;
`endif
        step(1);
        chk_time("reset", 5'd0, 6'd0, 6'd0);
        chk("reset_tics", {sec_tic, min_tic, hour_tic, day_tic, ld.load_err, alarm_hit, pm}, 0);
        mode_12h = 1'b1; #1;
        chk("reset_12h", {hour, pm}, {5'd12, 1'b0});
        mode_12h = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(3);
        chk("pre_first_tic", {sec, sec_tic}, {6'd0, 1'b0});
        step(1);
        chk("first_tic", {sec, sec_tic}, {6'd1, 1'b1});
        step(1);
        chk("tic_one_cycle", {sec, sec_tic}, {6'd1, 1'b0});
        step(3);
        chk("second_tic", {sec, sec_tic}, {6'd2, 1'b1});

        i_freq = 30'd1;
        step(1);
        chk("freq1_a", {sec, sec_tic}, {6'd3, 1'b1});
        step(1);
        chk("freq1_b", {sec, sec_tic}, {6'd4, 1'b1});

        i_freq = 30'd4;
        do_load(5'd0, 6'd0, 6'd59);
        chk_time("load_59", 5'd0, 6'd0, 6'd59);
        chk("load_no_tic", {sec_tic, ld.load_err}, 0);
        step(3);
        chk_time("hold_59", 5'd0, 6'd0, 6'd59);
        step(1);
        chk_time("sec_wrap", 5'd0, 6'd1, 6'd0);
        chk("sec_wrap_tics", {sec_tic, min_tic, hour_tic, day_tic}, 4'b1100);

        i_freq = 30'd2;
        do_load(5'd23, 6'd59, 6'd58);
        step(2);
        chk_time("pre_day", 5'd23, 6'd59, 6'd59);
        chk("pre_day_tics", {sec_tic, min_tic, hour_tic, day_tic}, 4'b1000);
        step(2);
        chk_time("day_wrap", 5'd0, 6'd0, 6'd0);
        chk("day_wrap_tics", {sec_tic, min_tic, hour_tic, day_tic}, 4'b1111);
        mode_12h = 1'b1; #1;
        chk("h12_midnight", {hour, pm}, {5'd12, 1'b0});
        mode_12h = 1'b0;

        en = 1'b0;
        step(1);
        do_load(5'd0, 6'd0, 6'd60);
        chk("bad_sec_err", ld.load_err, 1'b1);
        chk_time("bad_sec", 5'd0, 6'd0, 6'd0);
        step(1);
        chk("err_one_cycle", ld.load_err, 1'b0);
        do_load(5'd24, 6'd0, 6'd0);
        chk("bad_hour_err", ld.load_err, 1'b1);
        chk_time("bad_hour", 5'd0, 6'd0, 6'd0);
        do_load(5'd12, 6'd30, 6'd0);
        chk("good_load_err", ld.load_err, 1'b0);
        chk_time("good_load", 5'd12, 6'd30, 6'd0);
        mode_12h = 1'b1; #1;
        chk("h12_noon", {hour, pm}, {5'd12, 1'b1});
        do_load(5'd13, 6'd0, 6'd0);
        chk("h12_13", {hour, pm}, {5'd1, 1'b1});
        mode_12h = 1'b0; #1;
        chk("h24_13", {hour, pm}, {5'd13, 1'b1});

        en = 1'b1; i_freq = 30'd4;
        do_load(5'd13, 6'd0, 6'd0);
        step(2);
        en = 1'b0;
        tic_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (sec_tic) tic_cnt++;
        end
        chk("hold_no_tics", tic_cnt, 0);
        chk_time("hold_time", 5'd13, 6'd0, 6'd0);
        en = 1'b1;
        step(1);
        chk("resume_partial", {sec, sec_tic}, {6'd0, 1'b0});
        step(1);
        chk("resume_tic", {sec, sec_tic}, {6'd1, 1'b1});
        step(1);
        #2 reset_n = 1'b0;
        #1;
        chk_time("async_reset", 5'd0, 6'd0, 6'd0);
        chk("async_reset_flags", {sec_tic, pm, ld.load_err}, 0);
        step(1);
        reset_n = 1'b1;

        i_freq = 30'd2;
        do_load(5'd0, 6'd0, 6'd58);
        step(4);
        chk_time("alarm_time", 5'd0, 6'd1, 6'd0);
        chk("alarm_armed", {min_tic, alarm_hit}, {1'b1, exp_alarm});
        step(1);
        chk("alarm_one_cycle", alarm_hit, 1'b0);
        alarm_arm = 1'b0;
        do_load(5'd0, 6'd0, 6'd58);
        step(4);
        chk("alarm_disarmed", {min_tic, alarm_hit}, {1'b1, 1'b0});
        alarm_arm = 1'b1;
        do_load(5'd0, 6'd1, 6'd0);
        chk("alarm_on_load", alarm_hit, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
